// File: rtl/id_branch_resolve.sv
// ID-stage branch/jr resolution: operand forwarding mux, load-use stall FSM,
// outcome check against the BTB prediction, and registered redirect/BTB update.
module id_branch_resolve #(
   parameter int CNT_W          = 16,
   parameter int LOAD_EX_STALL  = 2,
   parameter int LOAD_MEM_STALL = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              branch_id,
   input  logic              bne_id,
   input  logic              jr_id,
   input  logic [4:0]        if_id_rs,
   input  logic [4:0]        if_id_rt,
   input  logic [1:0]        fwd_a,
   input  logic [1:0]        fwd_b,
   input  logic [31:0]       rs_data,
   input  logic [31:0]       rt_data,
   input  logic [31:0]       ex_fwd_data,
   input  logic [31:0]       mem_fwd_data,
   input  logic              id_ex_memread,
   input  logic              ex_mem_memread,
   input  logic [4:0]        id_ex_regdst,
   input  logic [4:0]        ex_mem_regdst,
   input  logic [31:0]       pc_plus4_id,
   input  logic [15:0]       imm_id,
   input  logic              pred_taken_id,
   input  logic [31:0]       pred_target_id,
   output logic              stall,
   output logic              redirect_valid,
   output logic [31:0]       redirect_pc,
   output logic              flush_if_id,
   output logic              btb_upd_valid,
   output logic [31:0]       btb_upd_pc,
   output logic              btb_upd_taken,
   output logic [31:0]       btb_upd_target,
   output logic [CNT_W-1:0]  mispredict_count
);

   typedef enum logic [1:0] {IDLE, STALL, RESOLVED} state_e;

   localparam int MAX_STALL = (LOAD_EX_STALL > LOAD_MEM_STALL) ? LOAD_EX_STALL : LOAD_MEM_STALL;
   localparam int SC_W      = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);

   state_e            state_q, state_d;
   logic [SC_W-1:0]   cnt_q, cnt_d;
   logic              redirect_valid_q, redirect_valid_d;
   logic [31:0]       redirect_pc_q, redirect_pc_d;
   logic              flush_q, flush_d;
   logic              btb_valid_q, btb_valid_d;
   logic [31:0]       btb_pc_q, btb_pc_d;
   logic              btb_taken_q, btb_taken_d;
   logic [31:0]       btb_target_q, btb_target_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [31:0]       op_a, op_b, br_target, target;
   logic              use_rs, use_rt, ex_hit, mem_hit, hazard;
   logic [SC_W-1:0]   stall_n;
   logic              eval, taken, mispredict;

   // NOTE: every signal assigned in an always_comb gets a default first, so no
   // path through the case/if leaves it unassigned and infers a latch.
   always_comb begin
      op_a = rs_data;
      case (fwd_a)
         2'b01:   op_a = ex_fwd_data;
         2'b10:   op_a = mem_fwd_data;
         default: op_a = rs_data;
      endcase
      op_b = rt_data;
      case (fwd_b)
         2'b01:   op_b = ex_fwd_data;
         2'b10:   op_b = mem_fwd_data;
         default: op_b = rt_data;
      endcase
   end

   // Register 0 is never produced by a load, so it never creates a hazard.
   always_comb begin
      use_rs  = branch_id | jr_id;
      use_rt  = branch_id;
      ex_hit  = id_ex_memread && (id_ex_regdst != 5'd0) &&
                ((use_rs && id_ex_regdst == if_id_rs) || (use_rt && id_ex_regdst == if_id_rt));
      mem_hit = ex_mem_memread && (ex_mem_regdst != 5'd0) &&
                ((use_rs && ex_mem_regdst == if_id_rs) || (use_rt && ex_mem_regdst == if_id_rt));
      hazard  = ex_hit | mem_hit;
      stall_n = '0;
      if (ex_hit)       stall_n = SC_W'(LOAD_EX_STALL);
      else if (mem_hit) stall_n = SC_W'(LOAD_MEM_STALL);
   end

   always_comb begin
      br_target = pc_plus4_id + {{14{imm_id[15]}}, imm_id, 2'b00};
      taken     = 1'b0;
      target    = br_target;
      if (jr_id) begin
         taken  = 1'b1;
         target = op_a;
      end else if (branch_id) begin
         taken  = bne_id ? (op_a != op_b) : (op_a == op_b);
      end
      mispredict = (taken != pred_taken_id) | (taken & (target != pred_target_id));
   end

   // FSM: state register
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (hazard) begin
               if (stall_n > SC_W'(1)) begin
                  state_d = STALL;
                  cnt_d   = stall_n - SC_W'(1);
               end
            end else if (eval && mispredict) begin
               state_d = RESOLVED;
            end
         end
         STALL: begin
            cnt_d = cnt_q - SC_W'(1);
            if (cnt_q == SC_W'(1)) state_d = IDLE;
         end
         RESOLVED: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // FSM: outputs. Stall is gated by reset so it drops the instant reset asserts.
   always_comb begin
      stall = rst_n & (((state_q == IDLE) & hazard) | (state_q == STALL));
      eval  = (state_q == IDLE) & ~hazard & (branch_id | jr_id | pred_taken_id);
   end

   always_comb begin
      redirect_valid_d = eval & mispredict;
      flush_d          = eval & mispredict;
      btb_valid_d      = eval;
      redirect_pc_d    = redirect_pc_q;
      btb_pc_d         = btb_pc_q;
      btb_taken_d      = btb_taken_q;
      btb_target_d     = btb_target_q;
      count_d          = count_q;
      if (eval) begin
         redirect_pc_d = taken ? target : pc_plus4_id;
         btb_pc_d      = pc_plus4_id - 32'd4;
         btb_taken_d   = taken;
         btb_target_d  = target;
      end
      if (eval && mispredict && (count_q != '1)) count_d = count_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         flush_q          <= 1'b0;
         btb_valid_q      <= 1'b0;
         btb_pc_q         <= '0;
         btb_taken_q      <= 1'b0;
         btb_target_q     <= '0;
         count_q          <= '0;
      end else begin
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         flush_q          <= flush_d;
         btb_valid_q      <= btb_valid_d;
         btb_pc_q         <= btb_pc_d;
         btb_taken_q      <= btb_taken_d;
         btb_target_q     <= btb_target_d;
         count_q          <= count_d;
      end
   end

   assign redirect_valid   = redirect_valid_q;
   assign redirect_pc      = redirect_pc_q;
   assign flush_if_id      = flush_q;
   assign btb_upd_valid    = btb_valid_q;
   assign btb_upd_pc       = btb_pc_q;
   assign btb_upd_taken    = btb_taken_q;
   assign btb_upd_target   = btb_target_q;
   assign mispredict_count = count_q;

endmodule

// File: tb/tb_id_branch_resolve.sv
// Directed bench for id_branch_resolve: expected resolutions are queued when an
// instruction is presented and compared one cycle later against the outputs.
module tb_id_branch_resolve;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              branch_id, bne_id, jr_id;
   logic [4:0]        if_id_rs, if_id_rt;
   logic [1:0]        fwd_a, fwd_b;
   logic [31:0]       rs_data, rt_data, ex_fwd_data, mem_fwd_data;
   logic              id_ex_memread, ex_mem_memread;
   logic [4:0]        id_ex_regdst, ex_mem_regdst;
   logic [31:0]       pc_plus4_id;
   logic [15:0]       imm_id;
   logic              pred_taken_id;
   logic [31:0]       pred_target_id;
   logic              stall, redirect_valid, flush_if_id, btb_upd_valid, btb_upd_taken;
   logic [31:0]       redirect_pc, btb_upd_pc, btb_upd_target;
   logic [CNT_W-1:0]  mispredict_count;

   id_branch_resolve #(.CNT_W(CNT_W), .LOAD_EX_STALL(2), .LOAD_MEM_STALL(1)) dut (
      .clk(clk), .rst_n(rst_n), .branch_id(branch_id), .bne_id(bne_id), .jr_id(jr_id),
      .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .rs_data(rs_data), .rt_data(rt_data), .ex_fwd_data(ex_fwd_data), .mem_fwd_data(mem_fwd_data),
      .id_ex_memread(id_ex_memread), .ex_mem_memread(ex_mem_memread),
      .id_ex_regdst(id_ex_regdst), .ex_mem_regdst(ex_mem_regdst),
      .pc_plus4_id(pc_plus4_id), .imm_id(imm_id), .pred_taken_id(pred_taken_id),
      .pred_target_id(pred_target_id), .stall(stall), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .flush_if_id(flush_if_id), .btb_upd_valid(btb_upd_valid),
      .btb_upd_pc(btb_upd_pc), .btb_upd_taken(btb_upd_taken), .btb_upd_target(btb_upd_target),
      .mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        redirect;
      logic [31:0] rpc;
      logic        taken;
      logic        chk_tgt;
      logic [31:0] target;
      logic [31:0] bpc;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   exp_count = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      branch_id = 0; bne_id = 0; jr_id = 0; if_id_rs = 0; if_id_rt = 0;
      fwd_a = 0; fwd_b = 0; rs_data = 0; rt_data = 0; ex_fwd_data = 0; mem_fwd_data = 0;
      id_ex_memread = 0; ex_mem_memread = 0; id_ex_regdst = 0; ex_mem_regdst = 0;
      pc_plus4_id = 0; imm_id = 0; pred_taken_id = 0; pred_target_id = 0;
   endtask

   task automatic set_branch(input logic bne, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [1:0] fa, input logic [1:0] fb,
                             input logic [31:0] rsd, input logic [31:0] rtd,
                             input logic [31:0] pc4, input logic [15:0] imm,
                             input logic pt, input logic [31:0] ptgt);
      branch_id = 1; bne_id = bne; jr_id = 0; if_id_rs = rs; if_id_rt = rt;
      fwd_a = fa; fwd_b = fb; rs_data = rsd; rt_data = rtd;
      pc_plus4_id = pc4; imm_id = imm; pred_taken_id = pt; pred_target_id = ptgt;
   endtask

   task automatic set_jr(input logic [4:0] rs, input logic [31:0] rsd, input logic [31:0] pc4,
                         input logic pt, input logic [31:0] ptgt);
      branch_id = 0; bne_id = 0; jr_id = 1; if_id_rs = rs; if_id_rt = 0;
      fwd_a = 0; fwd_b = 0; rs_data = rsd; pc_plus4_id = pc4;
      pred_taken_id = pt; pred_target_id = ptgt;
   endtask

   task automatic expect_eval(input logic redirect, input logic [31:0] rpc, input logic taken,
                              input logic chk_tgt, input logic [31:0] target, input logic [31:0] pc4);
      exp_t e;
      if (redirect && exp_count < CNT_MAX) exp_count++;
      e.redirect = redirect; e.rpc = rpc; e.taken = taken; e.chk_tgt = chk_tgt;
      e.target = target; e.bpc = pc4 - 32'd4; e.cnt = 32'(exp_count);
      sb_q.push_back(e);
   endtask

   task automatic check_eval(input string tag);
      exp_t e;
      check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check({tag, "_btb_valid"}, 32'(btb_upd_valid), 32'd1);
         check({tag, "_btb_pc"}, btb_upd_pc, e.bpc);
         check({tag, "_btb_taken"}, 32'(btb_upd_taken), 32'(e.taken));
         if (e.chk_tgt) check({tag, "_btb_target"}, btb_upd_target, e.target);
         check({tag, "_redirect"}, 32'(redirect_valid), 32'(e.redirect));
         check({tag, "_flush"}, 32'(flush_if_id), 32'(e.redirect));
         if (e.redirect) check({tag, "_redirect_pc"}, redirect_pc, e.rpc);
         check({tag, "_count"}, 32'(mispredict_count), e.cnt);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_redirect"}, 32'(redirect_valid), 32'd0);
      check({tag, "_flush"}, 32'(flush_if_id), 32'd0);
      check({tag, "_btb_valid"}, 32'(btb_upd_valid), 32'd0);
   endtask

   initial begin
      clear_inputs();
      rst_n = 0;
      #12;
      check("rst_stall", 32'(stall), 32'd0);
      check_quiet("rst");
      check("rst_redirect_pc", redirect_pc, 32'd0);
      check("rst_btb_pc", btb_upd_pc, 32'd0);
      check("rst_btb_taken", 32'(btb_upd_taken), 32'd0);
      check("rst_btb_target", btb_upd_target, 32'd0);
      check("rst_count", 32'(mispredict_count), 32'd0);
      rst_n = 1;
      tick();

      // beq taken, predicted not taken: redirect to 0x100 + 3*4
      set_branch(0, 5, 5, 2'b00, 2'b00, 32'h1234, 32'h1234, 32'h100, 16'h0003, 0, 0);
      expect_eval(1, 32'h10C, 1, 1, 32'h10C, 32'h100);
      #1 check("beq_stall", 32'(stall), 32'd0);
      tick(); clear_inputs(); check_eval("beq_taken");
      tick(); check_quiet("beq_resolved");

      // bne with opA forwarded from ID/EX (7) against rt_data 7: not taken
      set_branch(1, 5, 6, 2'b01, 2'b00, 32'd99, 32'd7, 32'h200, 16'hFFFF, 0, 0);
      ex_fwd_data = 32'd7;
      expect_eval(0, 32'h0, 0, 1, 32'h1FC, 32'h200);
      tick(); clear_inputs(); check_eval("bne_fwd");

      // jr on a load in ID/EX: two stall cycles, then correctly predicted
      set_jr(31, 32'h400, 32'h180, 1, 32'h400);
      id_ex_memread = 1; id_ex_regdst = 31;
      #1 check("jr_ex_stall0", 32'(stall), 32'd1);
      tick(); check_quiet("jr_ex_c0");
      id_ex_memread = 0;
      #1 check("jr_ex_stall1", 32'(stall), 32'd1);
      tick(); check_quiet("jr_ex_c1");
      expect_eval(0, 32'h0, 1, 1, 32'h400, 32'h180);
      #1 check("jr_ex_stall2", 32'(stall), 32'd0);
      tick(); clear_inputs(); check_eval("jr_ex");

      // jr on a load in EX/MEM: one stall cycle, then mispredicted
      set_jr(31, 32'h500, 32'h1C0, 0, 0);
      ex_mem_memread = 1; ex_mem_regdst = 31;
      #1 check("jr_mem_stall0", 32'(stall), 32'd1);
      tick(); check_quiet("jr_mem_c0");
      ex_mem_memread = 0;
      #1 check("jr_mem_stall1", 32'(stall), 32'd0);
      expect_eval(1, 32'h500, 1, 1, 32'h500, 32'h1C0);
      tick(); clear_inputs(); check_eval("jr_mem");
      tick(); check_quiet("jr_mem_resolved");

      // load to r0 with jr r0: no hazard
      set_jr(0, 32'h0, 32'h240, 1, 32'h0);
      id_ex_memread = 1; id_ex_regdst = 0;
      #1 check("r0_stall", 32'(stall), 32'd0);
      expect_eval(0, 32'h0, 1, 1, 32'h0, 32'h240);
      tick(); clear_inputs(); check_eval("jr_r0");

      // loads in both stages match: ID/EX stall length (2) applies
      set_branch(0, 3, 4, 2'b00, 2'b00, 32'd1, 32'd1, 32'h280, 16'h0000, 1, 32'h280);
      id_ex_memread = 1; id_ex_regdst = 4; ex_mem_memread = 1; ex_mem_regdst = 3;
      #1 check("prio_stall0", 32'(stall), 32'd1);
      tick();
      id_ex_memread = 0; ex_mem_memread = 0;
      #1 check("prio_stall1", 32'(stall), 32'd1);
      tick();
      #1 check("prio_stall2", 32'(stall), 32'd0);
      expect_eval(0, 32'h0, 1, 1, 32'h280, 32'h280);
      tick(); clear_inputs(); check_eval("prio");

      // correct taken prediction, then wrong predicted target
      set_branch(0, 5, 5, 2'b00, 2'b00, 32'h1234, 32'h1234, 32'h100, 16'h0003, 1, 32'h10C);
      expect_eval(0, 32'h0, 1, 1, 32'h10C, 32'h100);
      tick(); clear_inputs(); check_eval("pred_ok");
      set_branch(0, 5, 5, 2'b00, 2'b00, 32'h1234, 32'h1234, 32'h100, 16'h0003, 1, 32'h200);
      expect_eval(1, 32'h10C, 1, 1, 32'h10C, 32'h100);
      tick(); clear_inputs(); check_eval("pred_bad_tgt");
      tick(); check_quiet("pred_bad_resolved");

      // mispredict followed by a branch (with a load hazard) in RESOLVED
      set_branch(0, 2, 2, 2'b00, 2'b00, 32'h9, 32'h9, 32'h400, 16'h0010, 0, 0);
      expect_eval(1, 32'h440, 1, 1, 32'h440, 32'h400);
      tick();
      check_eval("wp_first");
      set_branch(0, 7, 7, 2'b10, 2'b10, 32'h0, 32'h0, 32'h404, 16'h0020, 0, 0);
      id_ex_memread = 1; id_ex_regdst = 7;
      #1 check("wp_resolved_stall", 32'(stall), 32'd0);
      tick(); clear_inputs(); check_quiet("wp_ignored");

      // BTB alias on a non-branch: not taken, redirect to fall-through
      pred_taken_id = 1; pred_target_id = 32'h999; pc_plus4_id = 32'h300;
      expect_eval(1, 32'h300, 0, 0, 32'h0, 32'h300);
      tick(); clear_inputs(); check_eval("alias");
      tick(); check_quiet("alias_resolved");

      // asynchronous reset in the middle of a stall
      set_jr(31, 32'h600, 32'h500, 1, 32'h600);
      id_ex_memread = 1; id_ex_regdst = 31;
      tick();
      #2 rst_n = 0;
      #1;
      exp_count = 0;
      check("rst_mid_stall", 32'(stall), 32'd0);
      check("rst_mid_count", 32'(mispredict_count), 32'd0);
      check("rst_mid_rpc", redirect_pc, 32'd0);
      clear_inputs();
      #2 rst_n = 1;
      #1 check("rst_release_stall", 32'(stall), 32'd0);
      tick(); check_quiet("rst_after");
      check("rst_after_stall", 32'(stall), 32'd0);

      // saturation: more mispredicts than the counter can hold
      for (int i = 0; i < CNT_MAX + 2; i++) begin
         pred_taken_id = 1; pred_target_id = 32'hDEAD0000; pc_plus4_id = 32'h1000 + 32'(i * 4);
         expect_eval(1, 32'h1000 + 32'(i * 4), 0, 0, 32'h0, 32'h1000 + 32'(i * 4));
         tick(); clear_inputs(); check_eval("sat");
         tick();
      end
      check("sat_final_count", 32'(mispredict_count), 32'(CNT_MAX));
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/id_branch_resolve.md
Name: id_branch_resolve

Overview:
- ID-stage branch/jr resolution block, directly downstream of the IF/ID forward unit.
- Consumes the forward selects to build the branch operands, compares them, and checks the outcome against the BTB prediction carried with the instruction.
- Produces the PC redirect, the IF/ID flush and the BTB update. Stalls ID when a branch source is still being loaded from memory.

Parameters:
- CNT_W, 16, width of the saturating mispredict counter.
- LOAD_EX_STALL, 2, stall cycles when the branch source is a load in ID/EX.
- LOAD_MEM_STALL, 1, stall cycles when the branch source is a load in EX/MEM.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- branch_id  in  1  beq/bne in ID
- bne_id  in  1  1=bne, 0=beq (valid with branch_id)
- jr_id  in  1  jr in ID
- if_id_rs, if_id_rt  in  5 each  source registers in ID
- fwd_a, fwd_b  in  2 each  forward selects: 00=regfile, 01=ID/EX, 10=EX/MEM, 11=regfile
- rs_data, rt_data  in  32 each  regfile read data
- ex_fwd_data  in  32  ID/EX-stage ALU result
- mem_fwd_data  in  32  EX/MEM ALU result
- id_ex_memread, ex_mem_memread  in  1 each  stage holds a load
- id_ex_regdst, ex_mem_regdst  in  5 each  destination register of that stage
- pc_plus4_id  in  32  PC+4 of the ID instruction
- imm_id  in  16  branch offset
- pred_taken_id  in  1  BTB predicted taken
- pred_target_id  in  32  BTB predicted target
- stall  out  1  hold PC and IF/ID, bubble into ID/EX
- redirect_valid  out  1  one-cycle pulse, load PC from redirect_pc
- redirect_pc  out  32  correct-path PC
- flush_if_id  out  1  one-cycle pulse, squash IF/ID
- btb_upd_valid  out  1  one-cycle pulse
- btb_upd_pc  out  32  pc_plus4_id − 4 of the resolved instruction
- btb_upd_taken  out  1  actual outcome
- btb_upd_target  out  32  actual target
- mispredict_count  out  CNT_W  saturating count of redirects

Behaviour:
- Reset: state IDLE, stall counter 0. All pulse outputs are 0, redirect_pc = 0, btb_upd_* = 0, mispredict_count = 0. Reset is asynchronous and can occur at any point, including mid-stall or in RESOLVED.
- Operand mux: opA from fwd_a, opB from fwd_b. 11 is treated as 00.
- Hazard:
  - Condition: (branch_id|jr_id) AND a load matches an in-use source. In-use sources are rs for branch and jr, and rt for branch only.
  - A source equal to register 0 never matches.
  - A load in ID/EX takes priority over a load in EX/MEM. If both match, LOAD_EX_STALL applies.
- FSM states:
  - IDLE: if hazard, stall=1 combinationally in this cycle. If N>1, go to STALL with cnt=N−1, otherwise stay in IDLE; hazard is re-evaluated next cycle. No evaluation takes place in a hazard cycle. With no hazard and (branch_id|jr_id|pred_taken_id), evaluate.
  - STALL: stall=1. cnt decrements each cycle. When cnt==1, return to IDLE at the next edge.
  - RESOLVED: entered for exactly one cycle after a redirect. The ID instruction in this cycle is wrong-path and is ignored: no evaluation, no stall. Returns to IDLE.
- Evaluation (cycle N, combinational):
  - beq: taken = (opA==opB). bne: taken = (opA!=opB).
  - Branch target = pc_plus4_id + (sext(imm_id)<<2), mod 2^32.
  - jr: taken = 1, target = opA.
  - Non-branch with pred_taken_id=1 (BTB alias): taken = 0.
  - mispredict = (taken != pred_taken_id) | (taken & target != pred_target_id).
- Outputs: all registered and asserted at cycle N+1 for one cycle.
  - btb_upd_* are asserted for every evaluated instruction.
  - redirect_valid, flush_if_id and a counter increment occur only on mispredict.
  - redirect_pc = taken ? target : pc_plus4_id.
  - On mispredict the FSM goes to RESOLVED.
- Counter: saturates at 2^CNT_W−1 and never wraps.

Test Plan:
- beq, rs=rt=5, fwd 00, both 0x1234, imm=0x0003, pc+4=0x100, pred_taken=0 → cycle N+1: redirect_valid=1, redirect_pc=0x10C, flush=1, btb_upd_taken=1, count=1.
- bne, opA via fwd_a=01 with ex_fwd_data=7, rt_data=7, pred_taken=0 → not taken, no redirect. btb_upd_valid=1, btb_upd_taken=0.
- jr rs=31, id_ex_memread=1, id_ex_regdst=31 → stall high for 2 cycles, then evaluation. Repeat with ex_mem_memread: stall for 1 cycle. Repeat with regdst=0 for a source of 0: no stall.
- Correct taken prediction (pred_target=0x10C as computed) → no redirect. Wrong target (pred_target=0x200) → redirect to 0x10C.
- Branch mispredict followed immediately by a branch in ID during RESOLVED → second branch ignored, single redirect pulse only.
- rst_n low during STALL → stall=0 asynchronously, state IDLE. Count preloaded to max via 2^CNT_W−1 mispredicts (CNT_W=4 override) → count stays 15.
